zclock_sched: RTL and testbench
===============================

ZCLOCK_SCHED -- requirements
Module: zclock_sched

Interface
REQ-001 SHALL have parameter SETTLE_LEN, default 4, meaning clk cycles of forced CPU stall after a turbo change (range 1..15).
REQ-002 SHALL have parameter MEM_TMO, default 15, meaning maximum clk cycles a memory stall may be held (range 1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state updates on posedge clk.
REQ-004 clk  in  1  28 MHz system clock.
REQ-005 rst  in  1  synchronous reset, active high.
REQ-006 turbo_req  in  2  requested CPU speed from the config register: 00=3.5, 01=7, 1x=14 MHz.
REQ-007 zpos  in  1  Z80 clock positive-edge strobe, one clk wide.
REQ-008 m1_n  in  1  Z80 M1, active low.
REQ-009 rfsh_n  in  1  Z80 RFSH, active low.
REQ-010 mem_req  in  1  one-cycle pulse: CPU memory cycle needs DRAM.
REQ-011 mem_ack  in  1  one-cycle pulse: DRAM arbiter has served the CPU.
REQ-012 turbo  out  2  applied speed, drives the Z80 clock generator.
REQ-013 cpu_stall  out  1  freeze Z80 clock.
REQ-014 sw_pending  out  1  high while a speed change is waiting for refresh.
REQ-015 mem_tmo  out  1  one-cycle pulse: memory stall released by timeout.

Function
REQ-016 Speed FSM SHALL have states IDLE, PEND, SETTLE.
REQ-017 IDLE: if turbo_req != turbo, go to PEND next cycle; otherwise stay.
REQ-018 PEND: target = turbo_req re-sampled every cycle (latest wins); sw_pending=1.
REQ-019 PEND: if turbo_req == turbo, return to IDLE without any change (cancel).
REQ-020 PEND: refresh event = zpos && !rfsh_n && m1_n in the same cycle; on it, turbo <= turbo_req of that cycle, load settle counter with SETTLE_LEN, go to SETTLE.
REQ-021 Refresh event with turbo_req == turbo SHALL take the cancel path (REQ-019), not SETTLE.
REQ-022 SETTLE: cpu_stall=1; counter decrements each cycle; at count 1 return to IDLE, so stall lasts exactly SETTLE_LEN cycles starting the cycle after the refresh event.
REQ-023 turbo SHALL change only on the REQ-020 transition; never elsewhere.
REQ-024 Memory stall SHALL only arm when turbo[1]=1 at the cycle mem_req is seen; in 3.5/7 MHz mem_req is ignored.
REQ-025 Armed memory stall: cpu_stall=1 from the cycle after mem_req until the cycle mem_ack is seen (inclusive of the mem_ack cycle, released the next).
REQ-026 mem_ack in the same cycle as mem_req SHALL NOT arm the stall.
REQ-027 Timeout counter 4 bits, cleared on arm, increments each stalled cycle; on reaching MEM_TMO, stall drops next cycle and mem_tmo pulses one cycle.
REQ-028 mem_req while memory stall is already armed SHALL be ignored (no restart of timeout).
REQ-029 mem_ack with no armed stall SHALL be ignored.
REQ-030 cpu_stall = settle stall OR memory stall; both may be active simultaneously and are independent.
REQ-031 A turbo change to non-14 MHz during an armed memory stall SHALL NOT cancel it; it ends by ack or timeout.
REQ-032 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-033 On rst: FSM=IDLE, turbo=00, cpu_stall=0, sw_pending=0, mem_tmo=0, all counters 0.
REQ-034 rst asserted mid-PEND, SETTLE or memory stall SHALL abort it in the next cycle without applying a pending turbo.

Verification
REQ-035 turbo_req 00->10, refresh event 20 cycles later -> sw_pending=1 for those cycles; turbo=10 the cycle after the event; cpu_stall high exactly 4 cycles.
REQ-036 turbo_req 00->01 then back to 00 before refresh -> return to IDLE, turbo stays 00, no stall.
REQ-037 turbo=10, mem_req, mem_ack 3 cycles later -> cpu_stall high 3 cycles, mem_tmo=0.
REQ-038 turbo=10, mem_req, no ack -> cpu_stall high 15 cycles, mem_tmo pulse, stall released.
REQ-039 turbo=01, mem_req -> no stall; zpos with rfsh_n=0 but m1_n=0 in PEND -> no switch.
REQ-040 rst during SETTLE and during PEND -> all outputs at reset values next cycle; turbo=00.

Source files
------------

// File: rtl/zclock_sched.sv
// Z80 clock scheduler: applies turbo changes only at refresh cycles with a
// settle stall, and stalls the CPU on 14 MHz DRAM accesses until ack or timeout.
module zclock_sched #(
  parameter int unsigned SETTLE_LEN = 4,
  parameter int unsigned MEM_TMO    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] turbo_req,
  input  logic       zpos,
  input  logic       m1_n,
  input  logic       rfsh_n,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic [1:0] turbo,
  output logic       cpu_stall,
  output logic       sw_pending,
  output logic       mem_tmo
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       turbo_q, turbo_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_inc;
  logic             mem_armed_q, mem_armed_d;
  logic             cpu_stall_q, cpu_stall_d;
  logic             sw_pending_q, sw_pending_d;
  logic             mem_tmo_q, mem_tmo_d;
  logic             refresh_ev;

  // A refresh cycle is the only safe point to retime the Z80 clock.
  assign refresh_ev  = zpos && !rfsh_n && m1_n;
  assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      turbo_q      <= 2'b00;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      mem_armed_q  <= 1'b0;
      cpu_stall_q  <= 1'b0;
      sw_pending_q <= 1'b0;
      mem_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      turbo_q      <= turbo_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_armed_q  <= mem_armed_d;
      cpu_stall_q  <= cpu_stall_d;
      sw_pending_q <= sw_pending_d;
      mem_tmo_q    <= mem_tmo_d;
    end
  end

  // Speed-change FSM; a request that matches the applied speed always cancels.
  always_comb begin
    state_d      = state_q;
    turbo_d      = turbo_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (turbo_req != turbo_q) state_d = PEND;
      end
      PEND: begin
        if (turbo_req == turbo_q) begin
          state_d = IDLE;
        end else if (refresh_ev) begin
          turbo_d      = turbo_req;
          settle_cnt_d = CNT_W'(SETTLE_LEN);
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q <= CNT_W'(1)) begin
          settle_cnt_d = '0;
          state_d      = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory stall: armed only at 14 MHz, released by ack (priority) or timeout.
  always_comb begin
    mem_armed_d = mem_armed_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_tmo_d   = 1'b0;
    if (mem_armed_q) begin
      if (mem_ack) begin
        mem_armed_d = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_inc;
        if (tmo_cnt_inc == CNT_W'(MEM_TMO)) begin
          mem_armed_d = 1'b0;
          mem_tmo_d   = 1'b1;
        end
      end
    end else if (mem_req && turbo_q[1] && !mem_ack) begin
      mem_armed_d = 1'b1;
      tmo_cnt_d   = '0;
    end
  end

  always_comb begin
    sw_pending_d = (state_d == PEND);
    cpu_stall_d  = (state_d == SETTLE) || mem_armed_d;
  end

  assign turbo      = turbo_q;
  assign cpu_stall  = cpu_stall_q;
  assign sw_pending = sw_pending_q;
  assign mem_tmo    = mem_tmo_q;

endmodule

// File: tb/tb_zclock_sched.sv
// Bench for zclock_sched: directed scenarios with literal expectations, then
// random traffic checked every cycle against a cycle-count behavioural model.
module tb_zclock_sched;

  localparam int unsigned SETTLE_LEN = 4;
  localparam int unsigned MEM_TMO    = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] turbo_req;
  logic       zpos, m1_n, rfsh_n, mem_req, mem_ack;
  logic [1:0] turbo;
  logic       cpu_stall, sw_pending, mem_tmo;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state: applied speed, waiting flag, remaining settle stall cycles,
  // memory stall flag with elapsed stalled cycles, and the timeout pulse.
  int m_turbo       = 0;
  bit m_pending     = 1'b0;
  int m_settle_left = 0;
  bit m_armed       = 1'b0;
  int m_elapsed     = 0;
  bit m_tmo         = 1'b0;

  zclock_sched #(.SETTLE_LEN(SETTLE_LEN), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst(rst), .turbo_req(turbo_req), .zpos(zpos), .m1_n(m1_n),
    .rfsh_n(rfsh_n), .mem_req(mem_req), .mem_ack(mem_ack), .turbo(turbo),
    .cpu_stall(cpu_stall), .sw_pending(sw_pending), .mem_tmo(mem_tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ev;
    int old_turbo;
    if (rst) begin
      m_turbo = 0; m_pending = 0; m_settle_left = 0;
      m_armed = 0; m_elapsed = 0; m_tmo = 0;
      return;
    end
    ev        = zpos && !rfsh_n && m1_n;
    old_turbo = m_turbo;
    m_tmo     = 1'b0;
    if (m_armed) begin
      if (mem_ack) m_armed = 1'b0;
      else begin
        m_elapsed++;
        if (m_elapsed >= int'(MEM_TMO)) begin
          m_armed = 1'b0;
          m_tmo   = 1'b1;
        end
      end
    end else if (mem_req && old_turbo >= 2 && !mem_ack) begin
      m_armed   = 1'b1;
      m_elapsed = 0;
    end
    if (m_settle_left > 0) begin
      m_settle_left--;
    end else if (!m_pending) begin
      if (int'(turbo_req) != m_turbo) m_pending = 1'b1;
    end else if (int'(turbo_req) == m_turbo) begin
      m_pending = 1'b0;
    end else if (ev) begin
      m_turbo       = int'(turbo_req);
      m_pending     = 1'b0;
      m_settle_left = int'(SETTLE_LEN);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    zpos = 1'b0; m1_n = 1'b1; rfsh_n = 1'b1; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic refresh_cycle();
    zpos = 1'b1; rfsh_n = 1'b0; m1_n = 1'b1;
    cyc();
    idle_inputs();
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("turbo", 32'(turbo), 32'(m_turbo));
      chk("sw_pending", 32'(sw_pending), 32'(m_pending));
      chk("cpu_stall", 32'(cpu_stall), 32'((m_settle_left > 0) || m_armed));
      chk("mem_tmo", 32'(mem_tmo), 32'(m_tmo));
    end
  end

  initial begin
    int cnt;
    int cnt2;
    rst = 1'b1; turbo_req = 2'b00;
    idle_inputs();
    cyc(); cyc();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_turbo", 32'(turbo), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_pending", 32'(sw_pending), 32'd0);
    chk("rst_tmo", 32'(mem_tmo), 32'd0);

    // Switch to 14 MHz with the refresh 20 cycles later.
    turbo_req = 2'b10;
    cyc();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (sw_pending) cnt++;
      cyc();
    end
    chk("pend_cycles", 32'(cnt), 32'd20);
    chk("turbo_before_ev", 32'(turbo), 32'd0);
    refresh_cycle();
    chk("turbo_after_ev", 32'(turbo), 32'd2);
    chk("pend_after_ev", 32'(sw_pending), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_stall) cnt++;
      cyc();
    end
    chk("settle_len", 32'(cnt), 32'(SETTLE_LEN));

    // Request a change then withdraw it before any refresh.
    turbo_req = 2'b01;
    cyc();
    chk("cancel_pend", 32'(sw_pending), 32'd1);
    turbo_req = 2'b10;
    cyc();
    chk("cancel_idle", 32'(sw_pending), 32'd0);
    chk("cancel_turbo", 32'(turbo), 32'd2);
    chk("cancel_stall", 32'(cpu_stall), 32'd0);

    // Memory stall released by ack three cycles after the request.
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (cpu_stall) cnt++;
      if (i == 2) mem_ack = 1'b1;
      cyc();
    end
    mem_ack = 1'b0;
    chk("ack_stall_len", 32'(cnt), 32'd3);
    chk("ack_released", 32'(cpu_stall), 32'd0);
    chk("ack_no_tmo", 32'(mem_tmo), 32'd0);

    // Memory stall with no ack runs into the timeout.
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_stall) cnt++;
      if (mem_tmo) cnt2++;
      cyc();
    end
    chk("tmo_stall_len", 32'(cnt), 32'(MEM_TMO));
    chk("tmo_pulses", 32'(cnt2), 32'd1);

    // At 7 MHz memory requests never stall; M1 refresh does not switch.
    turbo_req = 2'b01;
    cyc();
    refresh_cycle();
    for (int i = 0; i < 6; i++) cyc();
    chk("turbo_7", 32'(turbo), 32'd1);
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_stall) cnt++;
      cyc();
    end
    chk("no_stall_7", 32'(cnt), 32'd0);
    turbo_req = 2'b00;
    cyc();
    zpos = 1'b1; rfsh_n = 1'b0; m1_n = 1'b0;
    cyc();
    idle_inputs();
    chk("m1_no_switch", 32'(turbo), 32'd1);
    chk("m1_still_pend", 32'(sw_pending), 32'd1);

    // Reset while pending, then while settling with a memory stall armed.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstp_turbo", 32'(turbo), 32'd0);
    chk("rstp_pending", 32'(sw_pending), 32'd0);
    chk("rstp_stall", 32'(cpu_stall), 32'd0);
    turbo_req = 2'b10;
    cyc();
    refresh_cycle();
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0;
    chk("pre_rst_stall", 32'(cpu_stall), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    turbo_req = 2'b00;
    chk("rsts_turbo", 32'(turbo), 32'd0);
    chk("rsts_stall", 32'(cpu_stall), 32'd0);
    chk("rsts_pending", 32'(sw_pending), 32'd0);
    chk("rsts_tmo", 32'(mem_tmo), 32'd0);
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) turbo_req = 2'($urandom_range(3));
      zpos    = ($urandom_range(3) == 0);
      rfsh_n  = ($urandom_range(2) != 0);
      m1_n    = ($urandom_range(1) != 0);
      mem_req = ($urandom_range(7) == 0);
      mem_ack = ($urandom_range(9) == 0);
      rst     = ($urandom_range(399) == 0);
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
